// File: rtl/mem_stage_hs.sv
// mem_stage_hs: memory-access pipeline stage between execute and writeback.
// It holds a four-lane byte RAM, performs byte/half/word loads and stores with
// sign or zero extension, and handshakes valid/ready on both sides.
// A load's result appears READ_LATENCY cycles after it is accepted.
// Optional feature macro: MEM_MISALIGN_TRAP_EN. When it is defined, misaligned
// accesses are trapped: out_misalign=1, the store is suppressed and the load
// returns 0. When it is undefined, misaligned addresses are forced to alignment.
module mem_stage_hs #(
    parameter int XLEN         = 32,
    parameter int DEPTH_LOG2   = 12,
    parameter int READ_LATENCY = 1,
    parameter int REG_ADDR_W   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mem_read,
    input  logic                  in_mem_write,
    input  logic [2:0]            in_size,
    input  logic [XLEN-1:0]       in_addr,
    input  logic [XLEN-1:0]       in_wdata,
    input  logic [XLEN-1:0]       in_alu_result,
    input  logic                  in_branch,
    input  logic [XLEN-1:0]       in_branch_addr,
    input  logic                  in_reg_write,
    input  logic [REG_ADDR_W-1:0] in_write_reg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_branch,
    output logic [XLEN-1:0]       out_branch_addr,
    output logic                  out_reg_write,
    output logic [REG_ADDR_W-1:0] out_write_reg,
    output logic [XLEN-1:0]       out_reg_write_data,
    output logic                  out_misalign
);

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam bit         WAIT_USED = (READ_LATENCY > 1);
    localparam logic [1:0] LAT_M1    = 2'(READ_LATENCY - 1);

    // Elaboration-time parameter checks.
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("mem_stage_hs: READ_LATENCY must be in 1..4");
    end
    if (XLEN != 32) begin : g_bad_xlen
        $error("mem_stage_hs: XLEN must be 32");
    end

    // Size classes: 0 = byte, 1 = half, 2 = word.
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                r_state, w_state_next;
    logic [1:0]            r_cnt, w_cnt_next;

    // Output register set.
    logic                  r_out_valid;
    logic                  r_out_branch;
    logic [XLEN-1:0]       r_out_branch_addr;
    logic                  r_out_reg_write;
    logic [REG_ADDR_W-1:0] r_out_write_reg;
    logic [XLEN-1:0]       r_out_data;
    logic                  r_out_is_load;
    logic [1:0]            r_out_cls;
    logic [1:0]            r_out_lo;
    logic                  r_out_uns;
    logic                  r_out_misalign;

    // Side register: control captured at accept while a load waits for data.
    logic                  r_sd_branch;
    logic [XLEN-1:0]       r_sd_branch_addr;
    logic                  r_sd_reg_write;
    logic [REG_ADDR_W-1:0] r_sd_write_reg;
    logic [1:0]            r_sd_cls;
    logic [1:0]            r_sd_lo;
    logic                  r_sd_uns;
    logic                  r_sd_trap;

    logic                  w_accept;
    logic                  w_is_load;
    logic                  w_is_store;
    logic [1:0]            w_cls;
    logic                  w_uns;
    logic                  w_misalign;
    logic                  w_trap;
    logic [1:0]            w_lo;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [3:0]            w_lane_we;
    logic [31:0]           w_wdata_rep;
    logic                  w_rd_en;
    logic [31:0]           w_rdata;
    logic                  w_direct;
    logic                  w_wait_done;
    logic                  w_unused;

    // Addresses wrap: bits above the RAM index do not take part.
    assign w_unused = ^in_addr[XLEN-1:DEPTH_LOG2+2];

    assign in_ready   = (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    // A read+write op is a load, and it writes nothing.
    assign w_is_load  = in_mem_read;
    assign w_is_store = in_mem_write && !in_mem_read;

    // Codes other than byte/half (x00, x01) behave as lw; only lbu and lhu are unsigned.
    assign w_cls = (in_size[1:0] == 2'b00) ? 2'd0 :
                   (in_size[1:0] == 2'b01) ? 2'd1 : 2'd2;
    assign w_uns = in_size[2] && (w_cls != 2'd2);

    assign w_misalign = (w_is_load || w_is_store) &&
                        (((w_cls == 2'd1) && in_addr[0]) ||
                         ((w_cls == 2'd2) && (in_addr[1:0] != 2'b00)));
`ifdef MEM_MISALIGN_TRAP_EN
    assign w_trap = w_misalign;
`else
    assign w_trap = 1'b0;
`endif

    // Byte offset after forcing alignment for halves and words.
    assign w_lo  = (w_cls == 2'd0) ? in_addr[1:0] :
                   (w_cls == 2'd1) ? {in_addr[1], 1'b0} : 2'b00;
    assign w_idx = in_addr[DEPTH_LOG2+1:2];

    // Select the lanes a store touches and replicate its data across all lanes.
    always_comb begin
        w_lane_we   = 4'b0000;
        w_wdata_rep = in_wdata;
        case (w_cls)
            2'd0: begin
                w_lane_we   = 4'b0001 << w_lo;
                w_wdata_rep = {4{in_wdata[7:0]}};
            end
            2'd1: begin
                w_lane_we   = w_lo[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{in_wdata[15:0]}};
            end
            default: begin
                w_lane_we   = 4'b1111;
                w_wdata_rep = in_wdata;
            end
        endcase
        if (!(w_accept && w_is_store && !w_trap && rst_n)) begin
            w_lane_we = 4'b0000;
        end
    end

    assign w_rd_en = w_accept && w_is_load;

    // One byte-wide RAM per lane; reads are registered at the accept edge.
    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] r_mem [0:DEPTH-1];
        logic [7:0] r_rd_byte;

        // Lane write on store accept; lane read on load accept.
        always_ff @(posedge clk) begin
            if (w_lane_we[gi]) begin
                r_mem[w_idx] <= w_wdata_rep[gi*8 +: 8];
            end
            if (w_rd_en) begin
                r_rd_byte <= r_mem[w_idx];
            end
        end

        assign w_rdata[gi*8 +: 8] = r_rd_byte;
    end

    // Pick the byte or half selected by the offset, then sign- or zero-extend it.
    function automatic logic [31:0] f_extend(input logic [31:0] word, input logic [1:0] cls,
                                             input logic [1:0] lo, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (cls)
            2'd0:    return uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'd1:    return uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    // With a single-cycle read, a load's result register lands together with its
    // control, so it takes the same direct path as non-memory ops.
    assign w_direct    = !w_is_load || !WAIT_USED;
    // The counter reaches zero on this edge.
    assign w_wait_done = (r_state == S_WAIT) && (r_cnt == 2'd1);

    // FSM state and latency counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state: a multi-cycle load waits while the counter runs down.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_load && WAIT_USED) begin
                    w_state_next = S_WAIT;
                    w_cnt_next   = LAT_M1;
                end
            end
            S_WAIT: begin
                w_cnt_next = r_cnt - 2'd1;
                if (r_cnt == 2'd1) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 2'd0;
            end
        endcase
    end

    // Output and side registers: load on accept or at the end of a wait, clear valid on consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid       <= 1'b0;
            r_out_branch      <= 1'b0;
            r_out_branch_addr <= '0;
            r_out_reg_write   <= 1'b0;
            r_out_write_reg   <= '0;
            r_out_data        <= '0;
            r_out_is_load     <= 1'b0;
            r_out_cls         <= 2'd0;
            r_out_lo          <= 2'd0;
            r_out_uns         <= 1'b0;
            r_out_misalign    <= 1'b0;
            r_sd_branch       <= 1'b0;
            r_sd_branch_addr  <= '0;
            r_sd_reg_write    <= 1'b0;
            r_sd_write_reg    <= '0;
            r_sd_cls          <= 2'd0;
            r_sd_lo           <= 2'd0;
            r_sd_uns          <= 1'b0;
            r_sd_trap         <= 1'b0;
        end else if (w_accept) begin
            r_sd_branch      <= in_branch;
            r_sd_branch_addr <= in_branch_addr;
            r_sd_reg_write   <= in_reg_write && !w_trap;
            r_sd_write_reg   <= in_write_reg;
            r_sd_cls         <= w_cls;
            r_sd_lo          <= w_lo;
            r_sd_uns         <= w_uns;
            r_sd_trap        <= w_trap;
            if (w_direct) begin
                r_out_valid       <= 1'b1;
                r_out_branch      <= in_branch;
                r_out_branch_addr <= in_branch_addr;
                r_out_reg_write   <= in_reg_write && !w_trap;
                r_out_write_reg   <= in_write_reg;
                r_out_data        <= w_trap ? '0 : in_alu_result;
                r_out_is_load     <= w_is_load && !w_trap;
                r_out_cls         <= w_cls;
                r_out_lo          <= w_lo;
                r_out_uns         <= w_uns;
                r_out_misalign    <= w_trap;
            end else begin
                // The previous result was consumed on this edge.
                r_out_valid <= 1'b0;
            end
        end else if (w_wait_done) begin
            r_out_valid       <= 1'b1;
            r_out_branch      <= r_sd_branch;
            r_out_branch_addr <= r_sd_branch_addr;
            r_out_reg_write   <= r_sd_reg_write;
            r_out_write_reg   <= r_sd_write_reg;
            r_out_data        <= '0;
            r_out_is_load     <= !r_sd_trap;
            r_out_cls         <= r_sd_cls;
            r_out_lo          <= r_sd_lo;
            r_out_uns         <= r_sd_uns;
            r_out_misalign    <= r_sd_trap;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid          = r_out_valid;
    assign out_branch         = r_out_branch;
    assign out_branch_addr    = r_out_branch_addr;
    assign out_reg_write      = r_out_reg_write;
    assign out_write_reg      = r_out_write_reg;
    // Load data is extended from the registered RAM word. That word only changes on
    // a new accept, so it stays stable under back-pressure.
    assign out_reg_write_data = r_out_is_load ?
                                f_extend(w_rdata, r_out_cls, r_out_lo, r_out_uns) : r_out_data;
    // Without the trap feature this is constant 0, because w_trap is tied low.
    assign out_misalign       = r_out_misalign;

endmodule
